// File: rtl/mpu_ctlif_regs_pkg.sv
// Shared CSR map and bit positions for the MPU control/status interface.
package mpu_ctlif_regs_pkg;

  localparam logic [13:0] MPU_CSR_CTRL     = 14'h0;
  localparam logic [13:0] MPU_CSR_STAT     = 14'h1;
  localparam logic [13:0] MPU_CSR_UDATA_LO = 14'h2;
  localparam logic [13:0] MPU_CSR_UDATA_HI = 14'h3;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_RUN    = 1;
  localparam int STAT_ERR    = 0;
  localparam int STAT_USR    = 1;

endpackage

// File: rtl/mpu_ctlif_regs.sv
// CSR control/status block for the MPU: run/reset control, event latching
// with 64-bit user payload capture, and a level interrupt.
module mpu_ctlif_regs
  import mpu_ctlif_regs_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        mpu_clk,
  output logic        mpu_en,
  output logic        mpu_rst,
  input  logic        user_irq,
  input  logic [63:0] user_data,
  input  logic        error,
  output logic        irq
);

  logic        sel;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        err_rise;
  logic        usr_rise;
  logic        any_rise;
  logic        irq_en;
  logic        run;
  logic        err_evt;
  logic        usr_evt;
  logic [63:0] udata;
  logic        error_p1;
  logic        user_irq_p1;
  logic [31:0] rd_data;
  logic        unused_bits;

  // mpu_clk shares the sys_clk net; only the page and index address bits decode.
  assign unused_bits = ^{mpu_clk, csr_a[9:3]};

  assign sel      = (csr_a[13:10] == csr_addr);
  assign wr_ctrl  = csr_we & sel & (csr_a[2:0] == MPU_CSR_CTRL[2:0]);
  assign wr_stat  = csr_we & sel & (csr_a[2:0] == MPU_CSR_STAT[2:0]);
  assign err_rise = error & ~error_p1;
  assign usr_rise = user_irq & ~user_irq_p1;
  assign any_rise = err_rise | usr_rise;
  assign mpu_en   = run;

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (csr_a[2:0])
        MPU_CSR_CTRL[2:0]:     rd_data = {30'b0, run, irq_en};
        MPU_CSR_STAT[2:0]:     rd_data = {30'b0, usr_evt, err_evt};
        MPU_CSR_UDATA_LO[2:0]: rd_data = udata[31:0];
        MPU_CSR_UDATA_HI[2:0]: rd_data = udata[63:32];
        default:               rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      error_p1    <= 1'b0;
      user_irq_p1 <= 1'b0;
      csr_do      <= '0;
      irq         <= 1'b0;
      mpu_rst     <= 1'b1;
      irq_en      <= 1'b0;
      run         <= 1'b0;
      err_evt     <= 1'b0;
      usr_evt     <= 1'b0;
      udata       <= '0;
    end else begin
      error_p1    <= error;
      user_irq_p1 <= user_irq;
      csr_do      <= rd_data;
      irq         <= irq_en & (err_evt | usr_evt);
      // Start pulse only on a genuine 0->1 of run that no event overrides.
      mpu_rst     <= wr_ctrl & csr_di[CTRL_RUN] & ~run & ~any_rise;

      if (wr_ctrl) begin
        irq_en <= csr_di[CTRL_IRQ_EN];
        run    <= csr_di[CTRL_RUN];
      end
      if (any_rise) run <= 1'b0;

      // Later assignment wins: a same-cycle event beats a W1C clear.
      if (wr_stat && csr_di[STAT_ERR]) err_evt <= 1'b0;
      if (err_rise) err_evt <= 1'b1;
      if (wr_stat && csr_di[STAT_USR]) usr_evt <= 1'b0;
      if (usr_rise) begin
        usr_evt <= 1'b1;
        udata   <= user_data;
      end
    end
  end

endmodule

// File: tb/tb_mpu_ctlif_regs.sv
// Self-checking bench for mpu_ctlif_regs: directed scenarios plus randomized
// traffic compared against a register-level reference model.
module tb_mpu_ctlif_regs;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        mpu_en;
  logic        mpu_rst;
  logic        user_irq = 1'b0;
  logic [63:0] user_data = '0;
  logic        error = 1'b0;
  logic        irq;

  int checks = 0;
  int passed = 0;

  // input levels held across cycles
  logic        err_lvl = 1'b0;
  logic        uirq_lvl = 1'b0;
  logic [63:0] ud_lvl = '0;

  // reference model state
  logic        m_irq_en, m_run, m_err, m_usr, m_prev_e, m_prev_u;
  logic        m_irq, m_rst;
  logic [63:0] m_udata;
  logic [31:0] m_do;

  localparam logic [13:0] A_CTRL = 14'h0;
  localparam logic [13:0] A_STAT = 14'h1;
  localparam logic [13:0] A_LO   = 14'h2;
  localparam logic [13:0] A_HI   = 14'h3;

  always #5 sys_clk = ~sys_clk;

  mpu_ctlif_regs #(.csr_addr(4'h0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
    .csr_di(csr_di), .csr_do(csr_do), .mpu_clk(sys_clk), .mpu_en(mpu_en),
    .mpu_rst(mpu_rst), .user_irq(user_irq), .user_data(user_data),
    .error(error), .irq(irq)
  );

  function automatic logic [31:0] model_read(input logic [13:0] a);
    if (a[13:10] != 4'h0) return 32'h0;
    case (a[2:0])
      3'd0:    return {30'b0, m_run, m_irq_en};
      3'd1:    return {30'b0, m_usr, m_err};
      3'd2:    return m_udata[31:0];
      3'd3:    return m_udata[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_irq_en = 0; m_run = 0; m_err = 0; m_usr = 0; m_prev_e = 0; m_prev_u = 0;
    m_irq = 0; m_rst = 1; m_udata = '0; m_do = '0;
  endtask

  // Register-level behaviour for one clock edge, from the register map rules.
  task automatic model_step(input logic we, input logic [13:0] a, input logic [31:0] di);
    logic rise_e, rise_u, wr, is_ctrl, is_stat;
    rise_e  = err_lvl && !m_prev_e;
    rise_u  = uirq_lvl && !m_prev_u;
    wr      = we && (a[13:10] == 4'h0);
    is_ctrl = wr && (a[2:0] == 3'd0);
    is_stat = wr && (a[2:0] == 3'd1);
    m_do    = model_read(a);
    m_irq   = m_irq_en && (m_err || m_usr);
    m_rst   = is_ctrl && di[1] && !m_run && !(rise_e || rise_u);
    if (is_ctrl) begin m_irq_en = di[0]; m_run = di[1]; end
    if (rise_e || rise_u) m_run = 0;
    if (is_stat && di[0]) m_err = 0;
    if (is_stat && di[1]) m_usr = 0;
    if (rise_e) m_err = 1;
    if (rise_u) begin m_usr = 1; m_udata = ud_lvl; end
    m_prev_e = err_lvl;
    m_prev_u = uirq_lvl;
  endtask

  task automatic cycle(input logic we, input logic [13:0] a, input logic [31:0] di);
    @(negedge sys_clk);
    csr_we = we; csr_a = a; csr_di = di;
    error = err_lvl; user_irq = uirq_lvl; user_data = ud_lvl;
    model_step(we, a, di);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    checks++; if (csr_do !== 32'h0) $display("FAIL rst_csr_do got %h exp %h", csr_do, 32'h0); else passed++;
    checks++; if (mpu_en !== 1'b0) $display("FAIL rst_mpu_en got %b exp 0", mpu_en); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else passed++;
    checks++; if (mpu_rst !== 1'b1) $display("FAIL rst_mpu_rst got %b exp 1", mpu_rst); else passed++;
    sys_rst = 1;
    cycle(0, A_CTRL, 0);
    checks++; if (mpu_rst !== 1'b0) $display("FAIL rst_release_mpu_rst got %b exp 0", mpu_rst); else passed++;
    checks++; if (csr_do !== 32'h0) $display("FAIL rst_read_ctrl got %h exp %h", csr_do, 32'h0); else passed++;
  endtask

  task automatic test_ctrl();
    cycle(1, A_CTRL, 32'h1);
    cycle(0, A_CTRL, 0);
    checks++; if (csr_do !== 32'h1) $display("FAIL ctrl_read got %h exp %h", csr_do, 32'h1); else passed++;
    checks++; if (mpu_en !== 1'b0) $display("FAIL ctrl_en_idle got %b exp 0", mpu_en); else passed++;
    cycle(1, A_CTRL, 32'h3);
    checks++; if (mpu_en !== 1'b1) $display("FAIL ctrl_run_en got %b exp 1", mpu_en); else passed++;
    checks++; if (mpu_rst !== 1'b1) $display("FAIL ctrl_rst_pulse got %b exp 1", mpu_rst); else passed++;
    cycle(0, A_CTRL, 0);
    checks++; if (mpu_rst !== 1'b0) $display("FAIL ctrl_rst_end got %b exp 0", mpu_rst); else passed++;
    cycle(1, A_CTRL, 32'h3);
    checks++; if (mpu_rst !== 1'b0) $display("FAIL ctrl_rst_rewrite got %b exp 0", mpu_rst); else passed++;
  endtask

  task automatic test_error();
    err_lvl = 1;
    repeat (10) cycle(0, A_STAT, 0);
    checks++; if (csr_do !== 32'h1) $display("FAIL err_stat got %h exp %h", csr_do, 32'h1); else passed++;
    checks++; if (mpu_en !== 1'b0) $display("FAIL err_en got %b exp 0", mpu_en); else passed++;
    checks++; if (irq !== 1'b1) $display("FAIL err_irq got %b exp 1", irq); else passed++;
    cycle(1, A_STAT, 32'hffff_ffff);
    cycle(0, A_STAT, 0);
    checks++; if (csr_do !== 32'h0) $display("FAIL err_held_single got %h exp %h", csr_do, 32'h0); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL err_clr_irq got %b exp 0", irq); else passed++;
    err_lvl = 0;
    cycle(0, A_STAT, 0);
  endtask

  task automatic test_user();
    cycle(1, A_CTRL, 32'h3);
    uirq_lvl = 1; ud_lvl = 64'hffff_ffff_ffff_ffff;
    repeat (10) cycle(0, A_STAT, 0);
    checks++; if (csr_do !== 32'h2) $display("FAIL usr_stat got %h exp %h", csr_do, 32'h2); else passed++;
    checks++; if (mpu_en !== 1'b0) $display("FAIL usr_en got %b exp 0", mpu_en); else passed++;
    checks++; if (irq !== 1'b1) $display("FAIL usr_irq got %b exp 1", irq); else passed++;
    cycle(0, A_LO, 0);
    checks++; if (csr_do !== 32'hffff_ffff) $display("FAIL usr_lo got %h exp %h", csr_do, 32'hffff_ffff); else passed++;
    cycle(0, A_HI, 0);
    checks++; if (csr_do !== 32'hffff_ffff) $display("FAIL usr_hi got %h exp %h", csr_do, 32'hffff_ffff); else passed++;
    cycle(1, A_STAT, 32'hffff_ffff);
    cycle(0, A_LO, 0);
    checks++; if (irq !== 1'b0) $display("FAIL usr_clr_irq got %b exp 0", irq); else passed++;
    checks++; if (csr_do !== 32'hffff_ffff) $display("FAIL usr_udata_kept got %h exp %h", csr_do, 32'hffff_ffff); else passed++;
    uirq_lvl = 0;
    cycle(0, A_STAT, 0);
  endtask

  task automatic test_user_zero();
    uirq_lvl = 1; ud_lvl = 64'h0;
    cycle(0, A_STAT, 0);
    uirq_lvl = 0;
    cycle(0, A_STAT, 0);
    checks++; if (csr_do !== 32'h2) $display("FAIL zero_stat got %h exp %h", csr_do, 32'h2); else passed++;
    cycle(0, A_LO, 0);
    checks++; if (csr_do !== 32'h0) $display("FAIL zero_lo got %h exp %h", csr_do, 32'h0); else passed++;
    cycle(0, A_HI, 0);
    checks++; if (csr_do !== 32'h0) $display("FAIL zero_hi got %h exp %h", csr_do, 32'h0); else passed++;
    checks++; if (irq !== 1'b1) $display("FAIL zero_irq got %b exp 1", irq); else passed++;
    cycle(1, A_STAT, 32'h2);
    cycle(0, A_CTRL, 0);
    checks++; if (irq !== 1'b0) $display("FAIL zero_clr_irq got %b exp 0", irq); else passed++;
    checks++; if (csr_do !== 32'h1) $display("FAIL zero_ctrl got %h exp %h", csr_do, 32'h1); else passed++;
    cycle(0, {4'h7, 10'h0}, 0);
    checks++; if (csr_do !== 32'h0) $display("FAIL foreign_page got %h exp %h", csr_do, 32'h0); else passed++;
    cycle(1, {4'h7, 10'h0}, 32'h0);
    cycle(0, A_CTRL, 0);
    checks++; if (csr_do !== 32'h1) $display("FAIL foreign_write got %h exp %h", csr_do, 32'h1); else passed++;
  endtask

  task automatic test_collisions();
    err_lvl = 1;
    cycle(1, A_STAT, 32'hffff_ffff);
    cycle(0, A_STAT, 0);
    checks++; if (csr_do !== 32'h1) $display("FAIL clr_vs_err got %h exp %h", csr_do, 32'h1); else passed++;
    cycle(1, A_STAT, 32'h1);
    err_lvl = 0;
    cycle(0, A_STAT, 0);
    err_lvl = 1;
    cycle(1, A_CTRL, 32'h3);
    checks++; if (mpu_en !== 1'b0) $display("FAIL run_vs_err_en got %b exp 0", mpu_en); else passed++;
    checks++; if (mpu_rst !== 1'b0) $display("FAIL run_vs_err_rst got %b exp 0", mpu_rst); else passed++;
    cycle(1, A_CTRL, 32'h0);
    cycle(0, A_STAT, 0);
    cycle(0, A_STAT, 0);
    checks++; if (irq !== 1'b0) $display("FAIL masked_irq got %b exp 0", irq); else passed++;
    checks++; if (csr_do !== 32'h1) $display("FAIL masked_pending got %h exp %h", csr_do, 32'h1); else passed++;
    cycle(1, A_CTRL, 32'h1);
    cycle(0, A_CTRL, 0);
    checks++; if (irq !== 1'b1) $display("FAIL unmask_irq got %b exp 1", irq); else passed++;
    cycle(1, A_STAT, 32'h3);
    err_lvl = 0;
    cycle(0, A_CTRL, 0);
  endtask

  task automatic test_random();
    logic [13:0] a;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) err_lvl = ~err_lvl;
      if ($urandom_range(0, 4) == 0) uirq_lvl = ~uirq_lvl;
      ud_lvl = {$urandom, $urandom};
      a = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
           7'($urandom), 3'($urandom_range(0, 7))};
      cycle(($urandom_range(0, 2) == 0), a, $urandom);
      checks++; if (csr_do !== m_do) $display("FAIL rnd_do[%0d] got %h exp %h", i, csr_do, m_do); else passed++;
      checks++; if (mpu_en !== m_run) $display("FAIL rnd_en[%0d] got %b exp %b", i, mpu_en, m_run); else passed++;
      checks++; if (mpu_rst !== m_rst) $display("FAIL rnd_rst[%0d] got %b exp %b", i, mpu_rst, m_rst); else passed++;
      checks++; if (irq !== m_irq) $display("FAIL rnd_irq[%0d] got %b exp %b", i, irq, m_irq); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_error();
    test_user();
    test_user_zero();
    test_collisions();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
